// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout,s} = a + b + cin with two's-complement
// overflow flag and a valid strobe, one clock of latency, full throughput.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  // Carry chain: c[i] is the carry into bit i, c[WIDTH] the carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_q,   s_d;
  logic             cout_q, cout_d;
  logic             ovf_q,  ovf_d;
  logic             vld_q,  vld_d;

  assign c[0] = cin;

  // Chain of 1-bit full-adder cells, carry rippling from bit 0 upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  // Next state: load a fresh result on in_valid, otherwise hold the data
  // and drop the strobe so idle or X inputs never disturb the outputs.
  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    vld_d  = in_valid;
    if (in_valid) begin
      s_d    = sum;
      cout_d = c[WIDTH];
      ovf_d  = c[WIDTH-1] ^ c[WIDTH];
    end
  end

  // Output register; asynchronous reset clears result and strobe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       s1, cout1, ovf1, ov1;
  // WIDTH=8 instance
  logic       iv8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       cout8, ovf8, ov8;
  // WIDTH=16 instance
  logic        iv16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        cout16, ovf16, ov16;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .ovf(ovf1), .out_valid(ov1)
  );
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(cout8), .ovf(ovf8), .out_valid(ov8)
  );
  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .a(a16), .b(b16), .cin(cin16),
    .s(s16), .cout(cout16), .ovf(ovf16), .out_valid(ov16)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic a, b, cin;
    logic s, cout, ovf;
  } vec1_t;

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       cout, ovf;
  } vec8_t;

  vec1_t v1 [8];
  vec8_t v8 [6];

  initial begin
    // Hand-computed expected results, a is the MSB of the stimulus index.
    v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    v1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    v1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    v1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    v1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    v1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    v8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    v8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    v8[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    v8[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    v8[4] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    v8[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};

    // Reset state while rst is held high across edges.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s1",   s1,   0); chk("rst_cout1", cout1, 0);
    chk("rst_ovf1", ovf1, 0); chk("rst_ov1",   ov1,   0);
    chk("rst_s16",  s16,  0); chk("rst_ov16",  ov16,  0);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive WIDTH=1, back-to-back.
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("w1_s[%0d]", i-1),    s1,    v1[i-1].s);
        chk($sformatf("w1_cout[%0d]", i-1), cout1, v1[i-1].cout);
        chk($sformatf("w1_ovf[%0d]", i-1),  ovf1,  v1[i-1].ovf);
        chk($sformatf("w1_vld[%0d]", i-1),  ov1,   1);
      end
      if (i < 8) begin
        iv1 = 1'b1; a1 = v1[i].a; b1 = v1[i].b; cin1 = v1[i].cin;
      end else begin
        iv1 = 1'b0;
      end
    end

    // WIDTH=8 boundaries, back-to-back.
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("w8_s[%0d]", i-1),    s8,    v8[i-1].s);
        chk($sformatf("w8_cout[%0d]", i-1), cout8, v8[i-1].cout);
        chk($sformatf("w8_ovf[%0d]", i-1),  ovf8,  v8[i-1].ovf);
        chk($sformatf("w8_vld[%0d]", i-1),  ov8,   1);
      end
      if (i < 6) begin
        iv8 = 1'b1; a8 = v8[i].a; b8 = v8[i].b; cin8 = v8[i].cin;
      end else begin
        iv8 = 1'b0;
      end
    end

    // Hold: one valid result, then idle cycles with changing operands.
    @(negedge clk);
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    @(negedge clk);
    chk("hold_vld_pulse", ov1, 1);
    chk("hold_s0", s1, 0); chk("hold_cout0", cout1, 1); chk("hold_ovf0", ovf1, 1);
    for (int k = 0; k < 3; k++) begin
      iv1 = 1'b0; a1 = k[0]; b1 = ~k[0]; cin1 = k[1];
      @(negedge clk);
      chk($sformatf("hold_vld[%0d]", k),  ov1,   0);
      chk($sformatf("hold_s[%0d]", k),    s1,    0);
      chk($sformatf("hold_cout[%0d]", k), cout1, 1);
    end

    // Asynchronous reset between edges.
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    @(posedge clk);
    #2;
    iv1 = 1'b0;
    chk("ar_pre_vld", ov1, 1); chk("ar_pre_cout", cout1, 1);
    rst = 1'b1;
    #1;
    chk("ar_s",    s1,    0); chk("ar_cout", cout1, 0);
    chk("ar_ovf",  ovf1,  0); chk("ar_vld",  ov1,   0);
    @(negedge clk);
    rst = 1'b0;
    iv1 = 1'b1; a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0;
    @(negedge clk);
    iv1 = 1'b0;
    chk("ar_post_s", s1, 1); chk("ar_post_cout", cout1, 0);
    chk("ar_post_vld", ov1, 1);
    @(negedge clk);
    chk("ar_post_idle_vld", ov1, 0);

    // Random WIDTH=16 regression against an integer model.
    begin
      logic [15:0] es = '0;
      logic        ec = 1'b0, eo = 1'b0, ev = 1'b0;
      for (int n = 0; n <= 1000; n++) begin
        @(negedge clk);
        if (n > 0) begin
          chk("r16_vld", ov16, ev);
          chk("r16_s", s16, es);
          chk("r16_cout", cout16, ec);
          chk("r16_ovf", ovf16, eo);
        end
        iv16  = ($urandom_range(0, 3) != 0) && (n < 1000);
        a16   = 16'($urandom);
        b16   = 16'($urandom);
        cin16 = 1'($urandom);
        ev    = iv16;
        if (iv16) begin
          logic [16:0] full;
          int          sres;
          full = {1'b0, a16} + {1'b0, b16} + {16'b0, cin16};
          es   = full[15:0];
          ec   = full[16];
          sres = int'($signed(a16)) + int'($signed(b16)) + int'(cin16);
          eo   = (sres > 32767) || (sres < -32768);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
